// File: rtl/id_inst_queue.sv
// -----------------------------------------------------------------------------
// id_inst_queue
//
// Instruction buffer between IF and ID. Takes up to FETCH_W {pc, inst} entries
// per fetch beat into a circular store and presents up to ISSUE_W in-order slots
// to the ID decoders. A flush (exception, eret, branch redirect) or reset drops
// every entry.
//
// Optional feature (macro IQ_DS_PAIR_EN): branch/jump predecode so a branch is
// never presented without its delay slot. Either both go out in one group, or
// the branch goes out alone as the only slot (ISSUE_W=1) with its delay slot
// already buffered. Without the macro, out_valid is plain occupancy.
//
// Ports
//   clk         clock, all state on rising edge
//   resetn      synchronous reset, active low
//   flush       discard all entries this cycle (wins over push and pop)
//   in_valid    fetch beat valid
//   in_ready    room for a full FETCH_W beat (from registered count)
//   in_cnt      entries in the beat, 1..FETCH_W; slot i at in_pc + 4*i
//   in_pc       pc of beat slot 0
//   in_inst     slot i at [32*i+31:32*i]
//   out_valid   thermometer-coded slot valids
//   out_pc      per-slot pc
//   out_inst    per-slot instruction
//   id_allowin  ID consumes every valid slot this cycle
//   count       current occupancy
// -----------------------------------------------------------------------------
module id_inst_queue #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned FETCH_W = 2,
   parameter int unsigned ISSUE_W = 2
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   in_cnt,
   input  logic [31:0]                  in_pc,
   input  logic [32*FETCH_W-1:0]        in_inst,
   output logic [ISSUE_W-1:0]           out_valid,
   output logic [32*ISSUE_W-1:0]        out_pc,
   output logic [32*ISSUE_W-1:0]        out_inst,
   input  logic                         id_allowin,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   logic [31:0] mem_pc_q   [DEPTH];
   logic [31:0] mem_pc_d   [DEPTH];
   logic [31:0] mem_inst_q [DEPTH];
   logic [31:0] mem_inst_d [DEPTH];

   ptr_t rd_ptr_q, rd_ptr_d;
   ptr_t wr_ptr_q, wr_ptr_d;
   cnt_t count_q, count_d;

   logic push;
   logic pop;
   cnt_t push_n;
   cnt_t pop_n;

   logic [ISSUE_W-1:0] raw_valid;
   logic [31:0]        slot_pc   [ISSUE_W];
   logic [31:0]        slot_inst [ISSUE_W];

   // ---------------------------------------------------------------------------
   // Handshake and occupancy
   // ---------------------------------------------------------------------------
   // Pops in the same cycle are deliberately not credited: keeps in_ready off the
   // ID-side timing path.
   assign in_ready = (cnt_t'(DEPTH) - count_q) >= cnt_t'(FETCH_W);
   assign count    = count_q;
   assign push     = in_valid && in_ready && !flush;
   assign pop      = id_allowin && (|out_valid) && !flush;

   // ---------------------------------------------------------------------------
   // Slot read-out, straight from storage (no write bypass)
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < int'(ISSUE_W); i++) begin
         slot_pc[i]            = mem_pc_q[rd_ptr_q + ptr_t'(i)];
         slot_inst[i]          = mem_inst_q[rd_ptr_q + ptr_t'(i)];
         raw_valid[i]          = cnt_t'(i) < count_q;
         out_pc[32*i +: 32]    = slot_pc[i];
         out_inst[32*i +: 32]  = slot_inst[i];
      end
   end

`ifdef IQ_DS_PAIR_EN
   // Branch/jump: opcode 1..7 (regimm, j, jal, beq, bne, blez, bgtz),
   // or SPECIAL with func jr (8) / jalr (9).
   function automatic logic is_br(input logic [31:0] inst);
      logic [5:0] op;
      logic [5:0] fn;
      op = inst[31:26];
      fn = inst[5:0];
      return ((op != 6'd0) && (op <= 6'd7)) ||
             ((op == 6'd0) && ((fn == 6'd8) || (fn == 6'd9)));
   endfunction

   // Walk the slots in order. A branch is released only if its delay slot is
   // also buffered and either fits in this group or the branch is slot 0 (the
   // ISSUE_W=1 case, where the delay slot follows on the next pop). Otherwise
   // the branch and everything behind it are held back.
   always_comb begin
      logic [ISSUE_W:0] raw_ext;
      logic             stop;
      logic             pair;
      out_valid = '0;
      stop      = 1'b0;
      pair      = 1'b0;
      for (int i = 0; i <= int'(ISSUE_W); i++) begin
         raw_ext[i] = cnt_t'(i) < count_q;
      end
      for (int i = 0; i < int'(ISSUE_W); i++) begin
         if (!stop && raw_ext[i]) begin
            if (pair) begin
               // Delay slot of the previous branch.
               out_valid[i] = 1'b1;
               pair         = 1'b0;
            end else if (is_br(slot_inst[i])) begin
               if (raw_ext[i+1] && ((i + 1 < int'(ISSUE_W)) || (i == 0))) begin
                  out_valid[i] = 1'b1;
                  pair         = 1'b1;
               end else begin
                  stop = 1'b1;
               end
            end else begin
               out_valid[i] = 1'b1;
            end
         end else begin
            stop = 1'b1;
         end
      end
   end
`else
   assign out_valid = raw_valid;
`endif

   // ---------------------------------------------------------------------------
   // Pop size
   // ---------------------------------------------------------------------------
   always_comb begin
      pop_n = '0;
      for (int i = 0; i < int'(ISSUE_W); i++) begin
         if (out_valid[i]) begin
            pop_n = pop_n + cnt_t'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Storage write
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_pc_d   = mem_pc_q;
      mem_inst_d = mem_inst_q;
      push_n     = '0;
      if (push) begin
         push_n = cnt_t'(in_cnt);
         for (int i = 0; i < int'(FETCH_W); i++) begin
            if (cnt_t'(i) < cnt_t'(in_cnt)) begin
               mem_pc_d[wr_ptr_q + ptr_t'(i)]   = in_pc + 32'(4 * i);
               mem_inst_d[wr_ptr_q + ptr_t'(i)] = in_inst[32*i +: 32];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pointer / count next state
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(pop_n);
         end
         wr_ptr_d = wr_ptr_q + ptr_t'(push_n);
         count_d  = count_q + push_n - (pop ? pop_n : cnt_t'(0));
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      mem_pc_q   <= mem_pc_d;
      mem_inst_q <= mem_inst_d;
   end

`ifndef SYNTHESIS
   in_cnt_legal : assert property (@(posedge clk) disable iff (!resetn)
      push |-> ((in_cnt != 2'd0) && (32'(in_cnt) <= FETCH_W)));
`endif

endmodule

// File: tb/tb_id_inst_queue.sv
module tb_id_inst_queue;

   localparam int DEPTH   = 8;
   localparam int FETCH_W = 2;
   localparam int ISSUE_W = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_cnt;
   logic [31:0] in_pc;
   logic [63:0] in_inst;
   logic [1:0]  out_valid;
   logic [63:0] out_pc;
   logic [63:0] out_inst;
   logic        id_allowin;
   logic [3:0]  count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t exp_q[$];

   typedef struct {
      string       nm;
      bit          rst;
      bit          fl;
      bit          iv;
      logic [1:0]  cnt;
      logic [31:0] pc;
      bit          alw;
      int          ec;
      bit          er;
      logic [1:0]  eov;
   } vec_t;

   vec_t tbl[$];

   localparam logic [31:0] BEQ  = 32'h10000003;
   localparam logic [31:0] NOP  = 32'h00000000;
   localparam logic [31:0] ADDU = 32'h00851021;
   localparam logic [31:0] JR   = 32'h03e00008;

   id_inst_queue #(
      .DEPTH   (DEPTH),
      .FETCH_W (FETCH_W),
      .ISSUE_W (ISSUE_W)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_cnt     (in_cnt),
      .in_pc      (in_pc),
      .in_inst    (in_inst),
      .out_valid  (out_valid),
      .out_pc     (out_pc),
      .out_inst   (out_inst),
      .id_allowin (id_allowin),
      .count      (count)
   );

   always #5 clk = ~clk;

   // Non-branch filler (addiu) tagged with the low pc bits.
   function automatic logic [31:0] ainst(input logic [31:0] pc);
      return 32'h24000000 | {16'h0000, pc[15:0]};
   endfunction

`ifdef IQ_DS_PAIR_EN
   function automatic bit br(input logic [31:0] inst);
      int op;
      int fn;
      op = int'(inst[31:26]);
      fn = int'(inst[5:0]);
      return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
   endfunction
`endif

   // Expected slot valids from the scoreboard contents.
   function automatic logic [1:0] model_ov();
      int n;
      logic [1:0] v;
      n    = exp_q.size();
      v[0] = (n >= 1);
      v[1] = (n >= 2);
`ifdef IQ_DS_PAIR_EN
      if (n >= 1 && br(exp_q[0].inst)) v = (n >= 2) ? 2'b11 : 2'b00;
      else if (n >= 2 && br(exp_q[1].inst)) v = 2'b01;
`endif
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit rst, input bit fl, input bit iv, input logic [1:0] cnt,
                        input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                        input bit alw);
      resetn     = !rst;
      flush      = fl;
      in_valid   = iv;
      in_cnt     = cnt;
      in_pc      = pc;
      in_inst    = {i1, i0};
      id_allowin = alw;
      @(negedge clk);
   endtask

   // Scoreboard compare of the presented slots, then the clock edge, then the model update.
   task automatic commit();
      logic [1:0] mov;
      int         npop;
      bit         acc;
      mov = 2'b00;
      if (resetn) begin
         mov = model_ov();
         chk("sb_valid", {30'd0, out_valid}, {30'd0, mov});
         for (int s = 0; s < ISSUE_W; s++) begin
            if (mov[s]) begin
               chk("sb_pc", out_pc[32*s +: 32], exp_q[s].pc);
               chk("sb_inst", out_inst[32*s +: 32], exp_q[s].inst);
            end
         end
      end
      acc  = resetn && !flush && in_valid && (exp_q.size() <= DEPTH - FETCH_W);
      npop = (resetn && !flush && id_allowin) ? int'(mov[0]) + int'(mov[1]) : 0;
      @(posedge clk);
      #1;
      if (!resetn || flush) begin
         exp_q.delete();
      end else begin
         repeat (npop) void'(exp_q.pop_front());
         if (acc) begin
            for (int i = 0; i < int'(in_cnt); i++) begin
               exp_q.push_back('{pc: in_pc + 32'(4 * i), inst: in_inst[32*i +: 32]});
            end
         end
      end
   endtask

   task automatic add(input string nm, input bit rst, input bit fl, input bit iv,
                      input logic [1:0] cnt, input logic [31:0] pc, input bit alw,
                      input int ec, input bit er, input logic [1:0] eov);
      vec_t v;
      v = '{nm: nm, rst: rst, fl: fl, iv: iv, cnt: cnt, pc: pc, alw: alw,
            ec: ec, er: er, eov: eov};
      tbl.push_back(v);
   endtask

   initial begin
      logic [31:0] pc;

      // Expected count/in_ready/out_valid are the state before each row's edge.
      //   name          rst fl iv cnt pc            alw  cnt rdy ov
      add("reset_state", 0, 0, 1, 2, 32'hBFC00000, 0,   0, 1, 2'b00);
      add("fill1",       0, 0, 1, 2, 32'hBFC00008, 0,   2, 1, 2'b11);
      add("fill2",       0, 0, 1, 2, 32'hBFC00010, 0,   4, 1, 2'b11);
      add("fill3",       0, 0, 1, 2, 32'hBFC00018, 0,   6, 1, 2'b11);
      add("full_ign",    0, 0, 1, 2, 32'hBFC00020, 0,   8, 0, 2'b11);
      add("pop_grp",     0, 0, 0, 0, 32'h0,        1,   8, 0, 2'b11);
      add("after_pop",   0, 0, 0, 0, 32'h0,        1,   6, 1, 2'b11);
      add("drain4",      0, 0, 0, 0, 32'h0,        1,   4, 1, 2'b11);
      add("drain2",      0, 0, 0, 0, 32'h0,        1,   2, 1, 2'b11);
      add("empty_alw",   0, 0, 0, 0, 32'h0,        1,   0, 1, 2'b00);
      add("p5a",         0, 0, 1, 2, 32'h00000300, 0,   0, 1, 2'b00);
      add("p5b",         0, 0, 1, 2, 32'h00000308, 0,   2, 1, 2'b11);
      add("p5c",         0, 0, 1, 1, 32'h00000310, 0,   4, 1, 2'b11);
      add("flush_pp",    0, 1, 1, 2, 32'h00000400, 1,   5, 1, 2'b11);
      add("post_flush",  0, 0, 1, 2, 32'h00000500, 0,   0, 1, 2'b00);
      add("new_beat",    0, 0, 0, 0, 32'h0,        1,   2, 1, 2'b11);
      add("rst_fill",    0, 0, 1, 2, 32'h00000600, 0,   0, 1, 2'b00);
      add("rst_mid",     1, 0, 0, 0, 32'h0,        0,   2, 1, 2'b11);
      add("post_rst",    0, 0, 0, 0, 32'h0,        0,   0, 1, 2'b00);

      // Reset held for two cycles.
      drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      commit();
      drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      commit();

      foreach (tbl[k]) begin
         drive(tbl[k].rst, tbl[k].fl, tbl[k].iv, tbl[k].cnt, tbl[k].pc,
               ainst(tbl[k].pc), ainst(tbl[k].pc + 32'd4), tbl[k].alw);
         chk({tbl[k].nm, "_count"}, {28'd0, count}, 32'(tbl[k].ec));
         chk({tbl[k].nm, "_in_ready"}, {31'd0, in_ready}, {31'd0, tbl[k].er});
         chk({tbl[k].nm, "_out_valid"}, {30'd0, out_valid}, {30'd0, tbl[k].eov});
         commit();
      end

      // Streaming across pointer wrap: one beat in, one group out, every cycle.
      drive(0, 0, 1, 2, 32'h1000, ainst(32'h1000), ainst(32'h1004), 0);
      commit();
      for (int c = 1; c <= 20; c++) begin
         pc = 32'h1000 + 32'(8 * c);
         drive(0, 0, 1, 2, pc, ainst(pc), ainst(pc + 32'd4), 1);
         chk("wrap_count", {28'd0, count}, 32'd2);
         commit();
      end
      drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
      commit();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      chk("wrap_drained", {28'd0, count}, 32'd0);
      commit();

      // Branch waiting for its delay slot.
      drive(0, 0, 1, 1, 32'h100, BEQ, 32'h0, 0);
      commit();
      drive(0, 0, 1, 1, 32'h104, NOP, 32'h0, 0);
`ifdef IQ_DS_PAIR_EN
      chk("ds_pair_alone", {30'd0, out_valid}, 32'd0);
`else
      chk("ds_pair_alone", {30'd0, out_valid}, 32'd1);
`endif
      commit();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
      chk("ds_pair_valid", {30'd0, out_valid}, 32'd3);
      chk("ds_pair_pc0", out_pc[31:0], 32'h100);
      chk("ds_pair_pc1", out_pc[63:32], 32'h104);
      commit();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      chk("ds_pair_empty", {28'd0, count}, 32'd0);
      commit();

      // Branch in the last slot is held back until it becomes slot 0.
      drive(0, 0, 1, 2, 32'h200, ADDU, JR, 0);
      commit();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
`ifdef IQ_DS_PAIR_EN
      chk("ds_split_valid", {30'd0, out_valid}, 32'd1);
`else
      chk("ds_split_valid", {30'd0, out_valid}, 32'd3);
`endif
      commit();
      drive(0, 0, 1, 1, 32'h208, NOP, 32'h0, 0);
      chk("ds_split_wait", {30'd0, out_valid}, 32'd0);
`ifdef IQ_DS_PAIR_EN
      chk("ds_split_count", {28'd0, count}, 32'd1);
`else
      chk("ds_split_count", {28'd0, count}, 32'd0);
`endif
      commit();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
`ifdef IQ_DS_PAIR_EN
      chk("ds_split_group", {30'd0, out_valid}, 32'd3);
      chk("ds_split_pc0", out_pc[31:0], 32'h204);
`else
      chk("ds_split_group", {30'd0, out_valid}, 32'd1);
      chk("ds_split_pc0", out_pc[31:0], 32'h208);
`endif
      commit();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      chk("ds_split_empty", {28'd0, count}, 32'd0);
      commit();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
